das_pixel_scanner: RTL and testbench

Delay-and-sum beamforming scanner for the 16-mic (4x4) acoustic camera. On a start pulse it sweeps every pixel of the 60x45 image. For each pixel it:
- drives the pixel coordinate to the Delta_generator,
- registers the 16 returned per-mic delays,
- reads one delayed sample per mic from the circular sample buffer and sums them,
- squares the sum and emits the pixel power on a valid/ready stream toward the heat-map/VGA frame writer.

---
 rtl/das_pkg.sv | 44 ++++
 rtl/das_mac.sv | 41 ++++
 rtl/das_pixel_scanner.sv | 164 ++++++++++++++++
 tb/tb_das_pixel_scanner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/das_pkg.sv
// Shared constants, types and helpers for the delay-and-sum pixel scanner.
package das_pkg;

    localparam int PIXEL_COLUMN = 60;
    localparam int PIXEL_ROW    = 45;
    localparam int NUM_MIC      = 16;
    localparam int SAMPLE_W     = 16;
    localparam int BUF_AW       = 8;
    localparam int DELTA_W      = 8;
    localparam int COL_CENTER   = 30;
    localparam int ROW_CENTER   = 22;

    // Sixteen samples of SAMPLE_W bits sum into SAMPLE_W+4 bits without overflow.
    localparam int ACC_W = SAMPLE_W + 4;
    localparam int POW_W = 2 * ACC_W;
    localparam int MIC_W = $clog2(NUM_MIC);
    localparam int POS_W = 6;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [NUM_MIC-1:0][DELTA_W-1:0] delta_vec_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        SQUARE,
        OUT,
        DONE
    } scan_state_t;

    // Pixel index to centred coordinate for the Delta_generator.
    function automatic logic signed [POS_W-1:0] centre(input logic [POS_W-1:0] idx,
                                                        input int ctr);
        return signed'(idx - POS_W'(ctr));
    endfunction

    // Circular buffer read address: newest sample minus the mic delay, modulo buffer size.
    function automatic logic [BUF_AW-1:0] tap_addr(input logic [BUF_AW-1:0] wp,
                                                   input logic [DELTA_W-1:0] dly);
        return wp - BUF_AW'(dly);
    endfunction

endpackage

// File: rtl/das_mac.sv
// Delay-and-sum accumulator with a squaring output register.
module das_mac
    import das_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic             square,
    input  sample_t          din,
    output logic [POW_W-1:0] power
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] din_ext;
    logic signed [POW_W-1:0] sq;

    assign din_ext = {{(ACC_W-SAMPLE_W){din[SAMPLE_W-1]}}, din};
    assign sq      = acc * acc;

    // Running sum of the sixteen delayed samples for the current pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= acc + din_ext;
        end
    end

    // Pixel power; a square is never negative so the signed product is stored as unsigned.
    always_ff @(posedge clk) begin
        if (rst) begin
            power <= '0;
        end else if (square) begin
            power <= unsigned'(sq);
        end
    end

endmodule

// File: rtl/das_pixel_scanner.sv
// Frame scanner: walks every pixel, fetches per-mic delays, reads delayed samples,
// and streams the squared beam sum to the frame writer.
module das_pixel_scanner
    import das_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [BUF_AW-1:0]       i_wr_ptr,
    output logic                    o_busy,
    output logic signed [POS_W-1:0] o_p_x,
    output logic signed [POS_W-1:0] o_p_y,
    input  delta_vec_t              i_delta,
    output logic [MIC_W-1:0]        o_rd_mic,
    output logic [BUF_AW-1:0]       o_rd_addr,
    input  sample_t                 i_rd_data,
    output logic                    o_pix_valid,
    input  logic                    i_pix_ready,
    output logic [POS_W-1:0]        o_pix_col,
    output logic [POS_W-1:0]        o_pix_row,
    output logic [POW_W-1:0]        o_pix_power,
    output logic                    o_frame_done
);

    localparam logic [POS_W-1:0] LAST_COL = POS_W'(PIXEL_COLUMN - 1);
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(PIXEL_ROW - 1);
    localparam logic [MIC_W-1:0] LAST_MIC = MIC_W'(NUM_MIC - 1);

    scan_state_t             state, state_nx;
    logic [BUF_AW-1:0]       wr_ptr;
    logic [POS_W-1:0]        col, row, col_nx, row_nx;
    logic [MIC_W-1:0]        mic;
    delta_vec_t              delta_q;
    logic signed [POS_W-1:0] p_x, p_y;
    logic                    pix_valid;
    logic [POS_W-1:0]        pix_col, pix_row;
    logic [POW_W-1:0]        pix_power;
    logic [POW_W-1:0]        mac_power;
    logic                    col_wrap, last_pix, hs;
    logic                    mac_clr, mac_add, mac_sq;

    assign col_wrap = (col == LAST_COL);
    assign last_pix = col_wrap && (row == LAST_ROW);
    assign col_nx   = col_wrap ? '0 : col + POS_W'(1);
    assign row_nx   = col_wrap ? row + POS_W'(1) : row;
    assign hs       = pix_valid && i_pix_ready;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and MAC strobes. Read data lags its address by one cycle, so
    // the first ISSUE cycle adds nothing and DRAIN picks up the last mic.
    always_comb begin
        state_nx = state;
        mac_clr  = 1'b0;
        mac_add  = 1'b0;
        mac_sq   = 1'b0;
        case (state)
            IDLE:   if (i_start) state_nx = LOAD;
            LOAD: begin
                mac_clr  = 1'b1;
                state_nx = ISSUE;
            end
            ISSUE: begin
                mac_add = (mic != '0);
                if (mic == LAST_MIC) state_nx = DRAIN;
            end
            DRAIN: begin
                mac_add  = 1'b1;
                state_nx = SQUARE;
            end
            SQUARE: begin
                mac_sq   = 1'b1;
                state_nx = OUT;
            end
            OUT:    if (hs) state_nx = last_pix ? DONE : LOAD;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Scan counters, latched pointer and delays, centred coordinates and the
    // output register. OUT spends its first cycle loading the output register,
    // so valid rises one cycle after the square is available.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            col       <= '0;
            row       <= '0;
            mic       <= '0;
            delta_q   <= '0;
            p_x       <= '0;
            p_y       <= '0;
            pix_valid <= 1'b0;
            pix_col   <= '0;
            pix_row   <= '0;
            pix_power <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        wr_ptr <= i_wr_ptr;
                        col    <= '0;
                        row    <= '0;
                        p_x    <= centre('0, COL_CENTER);
                        p_y    <= centre('0, ROW_CENTER);
                    end
                end
                LOAD: begin
                    delta_q <= i_delta;
                    mic     <= '0;
                end
                ISSUE: mic <= mic + MIC_W'(1);
                OUT: begin
                    if (!pix_valid) begin
                        pix_valid <= 1'b1;
                        pix_col   <= col;
                        pix_row   <= row;
                        pix_power <= mac_power;
                    end else if (i_pix_ready) begin
                        pix_valid <= 1'b0;
                        if (!last_pix) begin
                            col <= col_nx;
                            row <= row_nx;
                            p_x <= centre(col_nx, COL_CENTER);
                            p_y <= centre(row_nx, ROW_CENTER);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    das_mac u_mac (
        .clk    (i_clk),
        .rst    (i_rst),
        .clr    (mac_clr),
        .add    (mac_add),
        .square (mac_sq),
        .din    (i_rd_data),
        .power  (mac_power)
    );

    // Read port is parked at zero outside ISSUE.
    assign o_rd_mic     = (state == ISSUE) ? mic : '0;
    assign o_rd_addr    = (state == ISSUE) ? tap_addr(wr_ptr, delta_q[mic]) : '0;

    assign o_busy       = (state != IDLE) && (state != DONE);
    assign o_frame_done = (state == DONE);
    assign o_p_x        = p_x;
    assign o_p_y        = p_y;
    assign o_pix_valid  = pix_valid;
    assign o_pix_col    = pix_col;
    assign o_pix_row    = pix_row;
    assign o_pix_power  = pix_power;

endmodule

// File: tb/tb_das_pixel_scanner.sv
// Directed bench for das_pixel_scanner with a behavioural delay generator and sample buffer.
module tb_das_pixel_scanner;
    import das_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [BUF_AW-1:0]       wr_ptr = '0;
    logic                    busy;
    logic signed [POS_W-1:0] p_x, p_y;
    delta_vec_t              delta;
    logic [MIC_W-1:0]        rd_mic;
    logic [BUF_AW-1:0]       rd_addr;
    sample_t                 rd_data = '0;
    logic                    pix_valid;
    logic                    pix_ready = 1'b1;
    logic [POS_W-1:0]        pix_col, pix_row;
    logic [POW_W-1:0]        pix_power;
    logic                    frame_done;

    int errors = 0;
    int checks = 0;

    // Stimulus knobs
    int      delta_base = 0;
    int      mem_mode   = 0;   // 0: constant, 1: mic0 returns its address, others 0
    sample_t const_val  = '0;
    bit      pow_chk    = 1'b0;
    longint  exp_pow    = 0;

    // Monitor state
    int hs_cnt = 0, order_err = 0, bad_pow = 0, fd_cnt = 0;
    int exp_col = 0, exp_row = 0;

    always #5 clk = ~clk;

    das_pixel_scanner dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_wr_ptr     (wr_ptr),
        .o_busy       (busy),
        .o_p_x        (p_x),
        .o_p_y        (p_y),
        .i_delta      (delta),
        .o_rd_mic     (rd_mic),
        .o_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .o_pix_valid  (pix_valid),
        .i_pix_ready  (pix_ready),
        .o_pix_col    (pix_col),
        .o_pix_row    (pix_row),
        .o_pix_power  (pix_power),
        .o_frame_done (frame_done)
    );

    // Delay generator stand-in: delta[m] = base + 3m + column index.
    always_comb begin
        delta = '0;
        for (int m = 0; m < NUM_MIC; m++)
            delta[m] = DELTA_W'(delta_base + 3 * m + int'(p_x) + COL_CENTER);
    end

    // Sample buffer: data for the address seen in a cycle appears the next cycle.
    sample_t nxt_data;
    always @(negedge clk)
        nxt_data = (mem_mode == 0) ? const_val
                 : ((rd_mic == '0) ? sample_t'({8'd0, rd_addr}) : sample_t'(0));
    always @(posedge clk) rd_data <= nxt_data;

    // Stream monitor: handshake count, scan order, power, frame-done pulses.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            exp_col = 0;
            exp_row = 0;
        end else begin
            if (pix_valid && pix_ready) begin
                hs_cnt++;
                if (int'(pix_col) != exp_col || int'(pix_row) != exp_row) order_err++;
                if (pow_chk && longint'(pix_power) != exp_pow) bad_pow++;
                if (exp_col == PIXEL_COLUMN - 1) begin
                    exp_col = 0;
                    exp_row++;
                end else begin
                    exp_col++;
                end
            end
            if (frame_done) begin
                fd_cnt++;
                exp_col = 0;
                exp_row = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pix(input int c, input int r, input int max_cyc, input string tag);
        bit found = 1'b0;
        for (int k = 0; k < max_cyc && !found; k++) begin
            @(negedge clk);
            if (pix_valid && int'(pix_col) == c && int'(pix_row) == r) found = 1'b1;
        end
        chk(tag, 64'(found), 64'd1);
    endtask

    task automatic wait_valid(input int max_cyc, input string tag);
        bit found = 1'b0;
        for (int k = 0; k < max_cyc && !found; k++) begin
            @(negedge clk);
            if (pix_valid) found = 1'b1;
        end
        chk(tag, 64'(found), 64'd1);
    endtask

    task automatic pulse_start(input logic [BUF_AW-1:0] wp);
        start  = 1'b1;
        wr_ptr = wp;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        time t0;
        time t_done;
        int  lat;
        int  fd0;
        bit  done_seen;
        bit  stall_ok;
        logic [POS_W-1:0] s_col, s_row;
        logic [POW_W-1:0] s_pow;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",  64'(busy), 0);
        chk("rst_valid", 64'(pix_valid), 0);
        chk("rst_done",  64'(frame_done), 0);
        chk("rst_px",    64'(p_x), 0);
        chk("rst_py",    64'(p_y), 0);
        chk("rst_mic",   64'(rd_mic), 0);
        chk("rst_addr",  64'(rd_addr), 0);
        chk("rst_col",   64'(pix_col), 0);
        chk("rst_row",   64'(pix_row), 0);
        chk("rst_pow",   64'(pix_power), 0);

        // ---------------- full frame, constant buffer 100 ----------------
        mem_mode   = 0;
        const_val  = 16'sd100;
        delta_base = 0;
        pow_chk    = 1'b1;
        exp_pow    = 2560000;
        t0 = $time;
        pulse_start(8'd5);

        // backpressure on pixel 3
        wait_pix(3, 0, 200, "bp_reach");
        pix_ready = 1'b0;
        s_col = pix_col;
        s_row = pix_row;
        s_pow = pix_power;
        stall_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(pix_valid && pix_col == s_col && pix_row == s_row && pix_power == s_pow
                  && rd_mic == '0 && rd_addr == '0)) stall_ok = 1'b0;
        end
        chk("bp_hold", 64'(stall_ok), 1);
        chk("bp_pow",  64'(s_pow), 2560000);
        pix_ready = 1'b1;

        // row wrap at column 59
        wait_pix(59, 0, 1400, "wrap_reach");
        wait_valid(40, "wrap_next");
        chk("wrap_col", 64'(pix_col), 0);
        chk("wrap_row", 64'(pix_row), 1);
        chk("wrap_px",  64'(p_x), -30);
        chk("wrap_py",  64'(p_y), -21);

        done_seen = 1'b0;
        for (int k = 0; k < 60000 && !done_seen; k++) begin
            @(negedge clk);
            if (frame_done) done_seen = 1'b1;
        end
        t_done = $time;
        chk("frame_done_seen", 64'(done_seen), 1);
        chk("frame_cycles", 64'((t_done - t0) / 10), 56706);
        repeat (20) @(negedge clk);
        chk("frame_busy_after", 64'(busy), 0);
        chk("frame_hs_cnt",     64'(hs_cnt), 2700);
        chk("frame_order",      64'(order_err), 0);
        chk("frame_bad_pow",    64'(bad_pow), 0);
        chk("frame_done_cnt",   64'(fd_cnt), 1);
        pow_chk = 1'b0;

        // ---------------- address check, ignored start, mid-frame reset ----------------
        mem_mode   = 1;
        delta_base = 149;
        start  = 1'b1;
        wr_ptr = 8'd10;
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                chk("b_load_px", 64'(p_x), -30);
                chk("b_load_py", 64'(p_y), -22);
                chk("b_busy",    64'(busy), 1);
            end
            if (k == 2) begin
                chk("b_mic0",  64'(rd_mic), 0);
                chk("b_addr0", 64'(rd_addr), 117);
                start  = 1'b1;     // ignored while busy
                wr_ptr = 8'd99;
            end
            if (k == 3) start = 1'b0;
            if (pix_valid) lat = k;
        end
        chk("b_latency", 64'(lat), 21);
        chk("b_col0",    64'(pix_col), 0);
        chk("b_row0",    64'(pix_row), 0);
        chk("b_pow0",    64'(pix_power), 13689);
        repeat (2) @(negedge clk);
        chk("b_p1_mic",  64'(rd_mic), 0);
        chk("b_p1_addr", 64'(rd_addr), 116);
        wait_pix(1, 0, 40, "b_p1_reach");
        chk("b_p1_pow",  64'(pix_power), 13456);

        wait_pix(39, 1, 2200, "b_p99_reach");
        repeat (7) @(negedge clk);
        chk("b_p100_mic",  64'(rd_mic), 5);
        chk("b_p100_addr", 64'(rd_addr), 62);
        rst = 1'b1;
        @(negedge clk);
        chk("b_rst_busy",  64'(busy), 0);
        chk("b_rst_valid", 64'(pix_valid), 0);
        chk("b_rst_mic",   64'(rd_mic), 0);
        chk("b_rst_addr",  64'(rd_addr), 0);
        rst = 1'b0;
        fd0 = fd_cnt;
        repeat (30) @(negedge clk);
        chk("b_no_done", 64'(fd_cnt - fd0), 0);
        chk("b_idle",    64'(busy), 0);

        // ---------------- restart, negative extremes, address wrap ----------------
        mem_mode   = 0;
        const_val  = -16'sd32768;
        delta_base = 147;
        pulse_start(8'd0);
        chk("c_px", 64'(p_x), -30);
        chk("c_py", 64'(p_y), -22);
        @(negedge clk);
        chk("c_addr0", 64'(rd_addr), 109);
        @(negedge clk);
        chk("c_mic1",  64'(rd_mic), 1);
        chk("c_addr1", 64'(rd_addr), 106);
        wait_pix(0, 0, 30, "c_reach");
        chk("c_pow", 64'(pix_power), 64'd274877906944);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
